register_file_mp: RTL
=====================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port MIPS register file: NUM_RD async read ports, two clocked write
//  ports, write-to-read bypass, hardwired zero register, per-register busy scoreboard.
//  Sits between decode (reads, busy query, busy set) and writeback (writes, busy clear).
//  Replaces register_files; adds clocked writes, reset, forwarding and hazard tracking.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD   2   number of read ports (1..4)
// PORTS
//  clk            in   1              clock; all state updates on rising edge
//  reset          in   1              asynchronous, active-high; clears all state
//  rd_addr        in   NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
//  rd_data        out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
//  rd_busy        out  NUM_RD         1 = register read on port i has a pending producer
//  wr_en0         in   1              write port 0 enable
//  wr_addr0       in   ADDR_W         write port 0 address
//  wr_data0       in   DATA_W         write port 0 data
//  wr_en1         in   1              write port 1 enable (priority port)
//  wr_addr1       in   ADDR_W         write port 1 address
//  wr_data1       in   DATA_W         write port 1 data
//  busy_set_en    in   1              mark busy_set_addr as awaiting a producer
//  busy_set_addr  in   ADDR_W         register to mark busy
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-write): all registers = 0, all busy bits = 0;
//    rd_data = 0 and rd_busy = 0 for every port while reset is high.
//  - Writes: committed on rising clk when wr_enN=1 and wr_addrN != 0; one-cycle latency.
//  - Same-address dual write: port 1 data is stored; port 0 is dropped.
//  - Register 0: writes ignored; reads always 0; never busy; busy_set to 0 ignored.
//  - Reads: combinational from rd_addr, zero cycle latency.
//  - Bypass: if rd_addr[i] != 0 and matches an enabled write address in the same cycle,
//    rd_data[i] = that write data (port 1 over port 0); otherwise the stored value.
//  - Busy bits: set on rising clk by busy_set_en; cleared on rising clk by any enabled write
//    to that address. Set and clear of the same register in one cycle: set wins (new
//    producer issued after the old one retires).
//  - rd_busy[i] = busy[rd_addr[i]] AND NOT (an enabled write to rd_addr[i] this cycle).
//    A busy_set in the current cycle does not affect rd_busy until the next cycle.
//  - Ports are independent. Any number of read ports may use the same address.
//  - No X propagation: reads of never-written registers return 0.
// STRUCTURE
//  - Shared include mips_defs.vh: REG_ZERO (0), DATA_W/ADDR_W defaults, NUM_RD upper bound.
//  - Sub-module rf_bypass_mux: one instance per read port (generate loop). Selects zero,
//    port 1 data, port 0 data, or the stored value, and computes rd_busy.
//  - Top holds the storage array and busy vector. Both use one async-reset always block.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, assert reset mid-cycle -> rd_data(r5)=0 immediately,
//    and still 0 after release.
//  2 Write/read: wr_en0, r2 <- 10; next cycle rd_addr0=2 -> rd_data0=10; r2 <- 20 later
//    -> 20 after edge.
//  3 Zero reg: wr_en1, r0 <- 0xFFFFFFFF; busy_set r0 -> rd_data(r0)=0, rd_busy=0 always.
//  4 Bypass/priority: wr0 r7<-0x11, wr1 r7<-0x22 same cycle; rd_addr0=7 -> 0x22 same
//    cycle; 0x22 stored.
//  5 Scoreboard: busy_set r9 -> rd_busy=0 that cycle, 1 next; wr r9<-5 -> rd_busy=0 and
//    data=5 same cycle; set+write r9 together -> busy=1 after edge.
//  6 NUM_RD=4, DATA_W=16: four ports read r1..r4 after writes 1..4 -> 1,2,3,4 concurrently.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file: zero-register index,
// default widths, read-port limit and the bypass source selector.
package register_file_mp_pkg;

  localparam int REG_ZERO   = 0;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_MAX = 4;

  typedef enum logic [1:0] {
    SEL_ZERO   = 2'd0,
    SEL_WR1    = 2'd1,
    SEL_WR0    = 2'd2,
    SEL_STORED = 2'd3
  } rd_sel_e;

  // Priority: zero register / reset, then write port 1, then write port 0, then storage.
  function automatic rd_sel_e pick_source(input logic zero_sel, input logic hit1, input logic hit0);
    rd_sel_e sel;
    if (zero_sel) begin
      sel = SEL_ZERO;
    end else if (hit1) begin
      sel = SEL_WR1;
    end else if (hit0) begin
      sel = SEL_WR0;
    end else begin
      sel = SEL_STORED;
    end
    return sel;
  endfunction

endpackage

// File: rtl/register_file_mp_rf_bypass_mux.sv
// Per-read-port source selection: zero register, same-cycle write data (port 1
// first) or the stored value, plus the forwarded busy indication.
module rf_bypass_mux
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic    zero_s;
  logic    hit0_s;
  logic    hit1_s;
  rd_sel_e sel_s;

  assign zero_s = reset || (rd_addr == ADDR_W'(REG_ZERO));
  assign hit0_s = wr_en0 && (wr_addr0 == rd_addr);
  assign hit1_s = wr_en1 && (wr_addr1 == rd_addr);
  assign sel_s  = pick_source(zero_s, hit1_s, hit0_s);

  // A forwarded value is by definition the retiring producer, so it is never busy.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    case (sel_s)
      SEL_ZERO: begin
        rd_data = '0;
        rd_busy = 1'b0;
      end
      SEL_WR1: begin
        rd_data = wr_data1;
        rd_busy = 1'b0;
      end
      SEL_WR0: begin
        rd_data = wr_data0;
        rd_busy = 1'b0;
      end
      SEL_STORED: begin
        rd_data = stored_data;
        rd_busy = stored_busy;
      end
      default: begin
        rd_data = '0;
        rd_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port MIPS register file: NUM_RD combinational read ports with write
// bypass, two clocked write ports (port 1 wins) and a per-register busy scoreboard.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en0,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic                     wr_en1,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic                     busy_set_en,
  input  logic [ADDR_W-1:0]        busy_set_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic              wr0_ok_s;
  logic              wr1_ok_s;
  logic              set_ok_s;

  if (NUM_RD < 1 || NUM_RD > NUM_RD_MAX) begin : g_num_rd_check
    $error("register_file_mp: NUM_RD out of range");
  end

  assign wr0_ok_s = wr_en0 && (wr_addr0 != ADDR_W'(REG_ZERO));
  assign wr1_ok_s = wr_en1 && (wr_addr1 != ADDR_W'(REG_ZERO));
  assign set_ok_s = busy_set_en && (busy_set_addr != ADDR_W'(REG_ZERO));

  // Storage and scoreboard; later assignments win, giving port 1 over port 0 and set over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        regs_r[j] <= '0;
      end
      busy_r <= '0;
    end else begin
      if (wr0_ok_s) begin
        regs_r[wr_addr0] <= wr_data0;
        busy_r[wr_addr0] <= 1'b0;
      end
      if (wr1_ok_s) begin
        regs_r[wr_addr1] <= wr_data1;
        busy_r[wr_addr1] <= 1'b0;
      end
      if (set_ok_s) begin
        busy_r[busy_set_addr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_port
    logic [ADDR_W-1:0] addr_s;

    assign addr_s = rd_addr[g*ADDR_W +: ADDR_W];

    rf_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_mux (
      .reset       (reset),
      .rd_addr     (addr_s),
      .stored_data (regs_r[addr_s]),
      .stored_busy (busy_r[addr_s]),
      .wr_en0      (wr_en0),
      .wr_addr0    (wr_addr0),
      .wr_data0    (wr_data0),
      .wr_en1      (wr_en1),
      .wr_addr1    (wr_addr1),
      .wr_data1    (wr_data1),
      .rd_data     (rd_data[g*DATA_W +: DATA_W]),
      .rd_busy     (rd_busy[g])
    );
  end

endmodule
